// File: rtl/kmeans_pkg.sv
// Shared definitions for the k=2, n=3 k-means blocks: loader FSM encoding and problem sizes.
package kmeans_pkg;

  localparam int unsigned NDim = 3;
  localparam int unsigned K    = 2;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRecv  = 2'd1,
    StFlush = 2'd2,
    StStart = 2'd3
  } loader_state_t;

endpackage

// File: rtl/kmeans_k2n3_data_loader.sv
// Loads a word-serial point stream (d0, d1, d2 per point) into the three dimension memories,
// then pulses kmeans_start so the core runs on the fresh dataset.
module kmeans_k2n3_data_loader
  import kmeans_pkg::*;
#(
  parameter int unsigned data_width               = 8,
  parameter int unsigned input_data_qty_bit_width = 8,
  parameter int unsigned input_data_qty           = 256
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                load_req,
  input  logic [input_data_qty_bit_width-1:0] load_qty,
  input  logic                                s_valid,
  input  logic [data_width-1:0]               s_data,
  output logic                                s_ready,
  output logic                                mem_wr_en,
  output logic [input_data_qty_bit_width-1:0] mem_wr_addr,
  output logic [data_width-1:0]               mem_d0_wr_data,
  output logic [data_width-1:0]               mem_d1_wr_data,
  output logic [data_width-1:0]               mem_d2_wr_data,
  output logic                                busy,
  output logic                                kmeans_start,
  output logic                                done
);

  localparam int unsigned Aw = input_data_qty_bit_width;
  localparam logic [Aw-1:0] LastAddr = Aw'(input_data_qty - 1);
  localparam logic [1:0]    LastIdx  = 2'(NDim - 1);

  loader_state_t state_q, state_d;

  logic [1:0]            w_idx_q;
  logic [Aw-1:0]         pt_cnt_q;
  logic [Aw-1:0]         qty_q;
  logic [data_width-1:0] d0_q, d1_q;

  logic accept, last_word, last_point;

  assign accept    = s_valid & s_ready;
  assign last_word = accept && (w_idx_q == LastIdx);
  // Pre-increment compare so a full-depth load never relies on pt_cnt wrapping; the
  // LastAddr term stops an out-of-range load_qty from running past the memory.
  assign last_point = (pt_cnt_q == qty_q) || (pt_cnt_q == LastAddr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (load_req) state_d = StRecv;
      StRecv:  if (last_word && last_point) state_d = StFlush;
      StFlush: state_d = StStart;
      StStart: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    s_ready      = (state_q == StRecv);
    busy         = (state_q != StIdle);
    kmeans_start = (state_q == StStart);
    done         = (state_q == StStart);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_idx_q        <= '0;
      pt_cnt_q       <= '0;
      qty_q          <= '0;
      d0_q           <= '0;
      d1_q           <= '0;
      mem_wr_en      <= 1'b0;
      mem_wr_addr    <= '0;
      mem_d0_wr_data <= '0;
      mem_d1_wr_data <= '0;
      mem_d2_wr_data <= '0;
    end else begin
      mem_wr_en <= 1'b0;
      if ((state_q == StIdle) && load_req) begin
        qty_q    <= load_qty;
        pt_cnt_q <= '0;
        w_idx_q  <= '0;
      end
      if (accept) begin
        case (w_idx_q)
          2'd0:    d0_q <= s_data;
          2'd1:    d1_q <= s_data;
          default: ;
        endcase
        w_idx_q <= last_word ? 2'd0 : w_idx_q + 2'd1;
      end
      // Third word goes straight to the write port; no need to latch it first.
      if (last_word) begin
        mem_wr_en      <= 1'b1;
        mem_wr_addr    <= pt_cnt_q;
        mem_d0_wr_data <= d0_q;
        mem_d1_wr_data <= d1_q;
        mem_d2_wr_data <= s_data;
        pt_cnt_q       <= pt_cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_kmeans_k2n3_data_loader.sv
// Scoreboard bench for the data loader: expected writes queued as words are accepted,
// checked and mirrored into a memory model as the DUT writes them.
module tb_kmeans_k2n3_data_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load_req = 1'b0;
  logic [7:0] load_qty = '0;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = '0;
  logic       s_ready, mem_wr_en, busy, kmeans_start, done;
  logic [7:0] mem_wr_addr, mem_d0_wr_data, mem_d1_wr_data, mem_d2_wr_data;

  kmeans_k2n3_data_loader #(
    .data_width              (8),
    .input_data_qty_bit_width(8),
    .input_data_qty          (256)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .load_req      (load_req),
    .load_qty      (load_qty),
    .s_valid       (s_valid),
    .s_data        (s_data),
    .s_ready       (s_ready),
    .mem_wr_en     (mem_wr_en),
    .mem_wr_addr   (mem_wr_addr),
    .mem_d0_wr_data(mem_d0_wr_data),
    .mem_d1_wr_data(mem_d1_wr_data),
    .mem_d2_wr_data(mem_d2_wr_data),
    .busy          (busy),
    .kmeans_start  (kmeans_start),
    .done          (done)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_err = 0;
  logic [31:0] sb[$];
  logic [7:0]  mem0[256];
  logic [7:0]  mem1[256];
  logic [7:0]  mem2[256];
  logic [23:0] stream[256];
  int          starts = 0;
  int          cyc = 0;
  int          last_wr = 0;
  bit          gap_chk = 1'b0;
  int          wi = 0;
  int          pt = 0;
  logic [7:0]  w0, w1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_wr_en) begin
        if (sb.size() == 0) begin
          check("extra_wr", 32'd1, 32'd0);
        end else begin
          logic [31:0] e;
          e = sb.pop_front();
          check("wr", {mem_wr_addr, mem_d0_wr_data, mem_d1_wr_data, mem_d2_wr_data}, e);
        end
        if (gap_chk && mem_wr_addr != 8'd0) check("wr_gap", 32'(cyc - last_wr), 32'd3);
        last_wr <= cyc;
        mem0[mem_wr_addr] <= mem_d0_wr_data;
        mem1[mem_wr_addr] <= mem_d1_wr_data;
        mem2[mem_wr_addr] <= mem_d2_wr_data;
      end
      if (kmeans_start) starts <= starts + 1;
      if (kmeans_start || done) check("start_eq_done", 32'(done), 32'(kmeans_start));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input logic [7:0] q);
    load_req = 1'b1;
    load_qty = q;
    tick();
    load_req = 1'b0;
    wi = 0;
    pt = 0;
    check("busy_after_req", 32'(busy), 32'd1);
  endtask

  task automatic push_word(input logic v, input logic [7:0] d);
    s_valid = v;
    s_data  = d;
    if (v && s_ready) begin
      case (wi)
        0: w0 = d;
        1: w1 = d;
        default: begin
          sb.push_back({8'(pt), w0, w1, d});
          pt++;
        end
      endcase
      wi = (wi == 2) ? 0 : wi + 1;
    end
    tick();
    s_valid = 1'b0;
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (!kmeans_start && n < 10) begin
      tick();
      n++;
    end
    check(tag, 32'(kmeans_start), 32'd1);
    tick();
  endtask

  int pat[8] = '{1, 0, 0, 1, 1, 0, 1, 1};

  initial begin
    int s0;
    int guard;
    logic [7:0] r;
    tick();
    tick();
    check("rst_outs", {s_ready, mem_wr_en, busy, kmeans_start, done, mem_wr_addr,
                       mem_d0_wr_data, mem_d1_wr_data, mem_d2_wr_data}, 32'd0);
    rst = 1'b0;
    tick();

    // Reset in the middle of a load: one point written, second point partial.
    start_load(8'd1);
    push_word(1'b1, 8'ha1);
    push_word(1'b1, 8'ha2);
    push_word(1'b1, 8'ha3);
    push_word(1'b1, 8'ha4);
    check("pre_rst_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1 check("async_rst_outs", {s_ready, mem_wr_en, busy, kmeans_start, done, mem_wr_addr,
                                mem_d0_wr_data, mem_d1_wr_data, mem_d2_wr_data}, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    wi = 0;
    pt = 0;
    for (int i = 0; i < 5; i++) tick();
    check("rst_no_pending", 32'(sb.size()), 32'd0);
    check("rst_idle", 32'(busy), 32'd0);
    start_load(8'd0);
    push_word(1'b1, 8'hb1);
    push_word(1'b1, 8'hb2);
    push_word(1'b1, 8'hb3);
    wait_start("rst_reload_start");

    // Single point, exact timing.
    s0 = starts;
    start_load(8'd0);
    push_word(1'b1, 8'h11);
    push_word(1'b1, 8'h22);
    push_word(1'b1, 8'h33);
    check("q0_wr_en", 32'(mem_wr_en), 32'd1);
    check("q0_addr", 32'(mem_wr_addr), 32'd0);
    check("q0_no_early_start", 32'(kmeans_start), 32'd0);
    tick();
    check("q0_start", {kmeans_start, done}, 32'd3);
    check("q0_wr_one_cycle", 32'(mem_wr_en), 32'd0);
    tick();
    check("q0_busy_fall", {busy, kmeans_start}, 32'd0);
    check("q0_start_cnt", 32'(starts - s0), 32'd1);

    // Four points back to back.
    s0 = starts;
    gap_chk = 1'b1;
    start_load(8'd3);
    for (int i = 0; i < 12; i++) push_word(1'b1, 8'($urandom));
    check("q3_flush_ready", 32'(s_ready), 32'd0);
    check("q3_last_addr", {31'd0, mem_wr_en} << 8 | 32'(mem_wr_addr), 32'h103);
    s_valid = 1'b1;
    tick();
    check("q3_start_ready", {s_ready, kmeans_start}, 32'd1);
    s_valid = 1'b0;
    tick();
    gap_chk = 1'b0;
    check("q3_start_cnt", 32'(starts - s0), 32'd1);
    check("q3_sb_empty", 32'(sb.size()), 32'd0);

    // Two points with bubbles on s_valid.
    s0 = starts;
    start_load(8'd1);
    for (int i = 0; i < 8; i++) push_word(pat[i][0], 8'($urandom));
    guard = 0;
    while ((wi != 0 || pt < 2) && guard < 10) begin
      push_word(1'b1, 8'($urandom));
      guard++;
    end
    wait_start("q1_start");
    check("q1_start_cnt", 32'(starts - s0), 32'd1);
    check("q1_sb_empty", 32'(sb.size()), 32'd0);

    // Full depth with readback.
    s0 = starts;
    start_load(8'd255);
    for (int p = 0; p < 256; p++) begin
      r = 8'($urandom);
      stream[p][23:16] = r;
      push_word(1'b1, r);
      r = 8'($urandom);
      stream[p][15:8] = r;
      push_word(1'b1, r);
      r = 8'($urandom);
      stream[p][7:0] = r;
      push_word(1'b1, r);
    end
    wait_start("full_start");
    tick();
    for (int p = 0; p < 256; p++)
      check("full_readback", {8'd0, mem0[p], mem1[p], mem2[p]}, {8'd0, stream[p]});
    check("full_start_cnt", 32'(starts - s0), 32'd1);
    check("full_sb_empty", 32'(sb.size()), 32'd0);

    // load_req outside IDLE is ignored; accepted again right after START.
    s0 = starts;
    start_load(8'd3);
    for (int i = 0; i < 5; i++) push_word(1'b1, 8'($urandom));
    load_req = 1'b1;
    load_qty = 8'd0;
    push_word(1'b1, 8'($urandom));
    load_req = 1'b0;
    for (int i = 0; i < 6; i++) push_word(1'b1, 8'($urandom));
    check("req_flush_no_start", 32'(kmeans_start), 32'd0);
    tick();
    check("req_in_start", 32'(kmeans_start), 32'd1);
    load_req = 1'b1;
    load_qty = 8'd7;
    tick();
    load_req = 1'b0;
    check("req_start_ignored", 32'(busy), 32'd0);
    check("req_sb_empty", 32'(sb.size()), 32'd0);
    start_load(8'd0);
    push_word(1'b1, 8'hc1);
    push_word(1'b1, 8'hc2);
    push_word(1'b1, 8'hc3);
    wait_start("req_after_start");
    check("req_start_cnt", 32'(starts - s0), 32'd2);
    check("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
